// File: rtl/xoodyak_seq_ctrl.sv
// Command sequencer for xoodyak_build: FIFO-buffered host commands replayed with a fixed hold window.
// Optional call-order checking (cyclist mode tracking) is enabled by defining XOODYAK_SEQ_CHECK_EN.
module xoodyak_seq_ctrl #(
  parameter int CMD_DEPTH   = 4,
  parameter int HOLD_CYCLES = 4
) (
  input  logic         eph1,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [4:0]   cmd_op,
  input  logic [351:0] cmd_data,
  output logic [4:0]   core_opmode,
  output logic [351:0] core_input_data,
  input  logic [191:0] core_textout,
  input  logic         core_textout_valid,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [191:0] rsp_text,
  output logic [1:0]   rsp_status,
  output logic         busy
);

  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam int CNT_W = $clog2(HOLD_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_e;

  logic [4:0]       fifo_op_q   [CMD_DEPTH];
  logic [351:0]     fifo_data_q [CMD_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [4:0]       op_q, op_d;
  logic [351:0]     data_q, data_d;
  logic [191:0]     text_q, text_d;
  logic [1:0]       status_q, status_d;
  logic             got_q, got_d;
  logic             push, pop;
  logic [4:0]       head_op;
  logic [351:0]     head_data;

  function automatic logic is_out_fn(input logic [3:0] fn);
    is_out_fn = (fn == 4'd4) || (fn == 4'd5) || (fn == 4'd6) || (fn == 4'd8);
  endfunction

`ifdef XOODYAK_SEQ_CHECK_EN
  typedef enum logic [1:0] {M_UNINIT, M_HASH, M_KEYED} mode_e;
  mode_e mode_q, mode_d;

  function automatic logic op_legal(input logic [4:0] op, input mode_e mode);
    case (op)
      5'h10, 5'h01:                      op_legal = 1'b1;
      5'h03, 5'h06:                      op_legal = (mode != M_UNINIT);
      5'h02, 5'h04, 5'h05, 5'h07, 5'h08: op_legal = (mode == M_KEYED);
      default:                           op_legal = 1'b0;
    endcase
  endfunction

  function automatic mode_e next_mode(input logic [4:0] op, input mode_e mode);
    if (op == 5'h10)      next_mode = M_HASH;
    else if (op == 5'h01) next_mode = M_KEYED;
    else                  next_mode = mode;
  endfunction
`endif

  assign cmd_ready       = (count_q != (PTR_W+1)'(CMD_DEPTH));
  assign push            = cmd_valid & cmd_ready;
  assign head_op         = fifo_op_q[rd_ptr_q];
  assign head_data       = fifo_data_q[rd_ptr_q];
  assign core_opmode     = (state_q == S_ISSUE) ? op_q : 5'h00;
  assign core_input_data = (state_q == S_ISSUE) ? data_q : '0;
  assign rsp_valid       = (state_q == S_RESP);
  assign rsp_text        = text_q;
  assign rsp_status      = status_q;
  assign busy            = (count_q != '0) || (state_q != S_IDLE);

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    op_d     = op_q;
    data_d   = data_q;
    text_d   = text_q;
    status_d = status_q;
    got_d    = got_q;
    pop      = 1'b0;
`ifdef XOODYAK_SEQ_CHECK_EN
    mode_d   = mode_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop      = 1'b1;
          text_d   = '0;
          status_d = 2'd0;
          got_d    = 1'b0;
          data_d   = head_data;
`ifdef XOODYAK_SEQ_CHECK_EN
          if (op_legal(head_op, mode_q)) begin
            mode_d  = next_mode(head_op, mode_q);
            op_d    = {mode_d == M_HASH, head_op[3:0]};
            hold_d  = CNT_W'(HOLD_CYCLES - 1);
            state_d = S_ISSUE;
          end else begin
            // Rejected commands never reach the core.
            status_d = 2'd1;
            state_d  = S_RESP;
          end
`else
          op_d    = head_op;
          hold_d  = CNT_W'(HOLD_CYCLES - 1);
          state_d = S_ISSUE;
`endif
        end
      end
      S_ISSUE: begin
        if (is_out_fn(op_q[3:0]) && core_textout_valid && !got_q) begin
          text_d = core_textout;
          got_d  = 1'b1;
        end
        if (hold_q == '0) begin
          state_d = S_RESP;
          if (is_out_fn(op_q[3:0]) && !got_d) status_d = 2'd2;
        end else begin
          hold_d = hold_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge eph1) begin
    if (reset) begin
      state_q  <= S_IDLE;
      hold_q   <= '0;
      got_q    <= 1'b0;
      text_q   <= '0;
      status_q <= 2'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
`ifdef XOODYAK_SEQ_CHECK_EN
      mode_q   <= M_UNINIT;
`endif
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      got_q    <= got_d;
      text_q   <= text_d;
      status_q <= status_d;
`ifdef XOODYAK_SEQ_CHECK_EN
      mode_q   <= mode_d;
`endif
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage carries no reset; the output muxes and control flags keep it invisible.
  always_ff @(posedge eph1) begin
    op_q   <= op_d;
    data_q <= data_d;
    if (push) begin
      fifo_op_q[wr_ptr_q]   <= cmd_op;
      fifo_data_q[wr_ptr_q] <= cmd_data;
    end
  end

endmodule

// File: tb/tb_xoodyak_seq_ctrl.sv
// Bench for xoodyak_seq_ctrl: directed command flows against a queue-based response/issue model.
module tb_xoodyak_seq_ctrl;
  localparam int DEPTH = 4;
  localparam int HOLD  = 4;

  localparam logic [191:0] HASH_TXT = 192'h87a0_c1d2_e3f4_0516_2738_49aa_bbcc_ddee_ff00_1122_3344_0e30;
  localparam logic [191:0] ENC_TXT  = 192'hfedc_ba98_7654_3210_0f1e_2d3c_4b5a_6978_8796_a5b4_c3d2_e1f0;
  localparam logic [351:0] ABSORB_D = {96'h6162636465666768696a6b6c, 256'h0};
  localparam logic [351:0] KEY_D    = {128'h38393a3b3c3d3e3f3031323334353637, 224'h0};
  localparam logic [351:0] NONCE_D  = {128'h494a4b4c4d4e4f404142434445464748, 224'h0};
  localparam logic [351:0] ENC_D    = {192'h4d4e_4f50_5152_5354_5556_5758_3132_3334_3536_3738_494a_4b4c, 160'h0};

`ifdef XOODYAK_SEQ_CHECK_EN
  localparam logic [4:0] ABS_OP  = 5'h13;
  localparam logic [4:0] SQZ_OP  = 5'h16;
  localparam logic [1:0] ILL_ST  = 2'd1;
  localparam int         ILL_WIN = 0;
`else
  localparam logic [4:0] ABS_OP  = 5'h03;
  localparam logic [4:0] SQZ_OP  = 5'h06;
  localparam logic [1:0] ILL_ST  = 2'd0;
  localparam int         ILL_WIN = 1;
`endif

  logic         eph1 = 1'b0;
  logic         reset = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [4:0]   cmd_op = '0;
  logic [351:0] cmd_data = '0;
  logic [4:0]   core_opmode;
  logic [351:0] core_input_data;
  logic [191:0] core_textout = '0;
  logic         core_textout_valid = 1'b0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [191:0] rsp_text;
  logic [1:0]   rsp_status;
  logic         busy;

  xoodyak_seq_ctrl #(.CMD_DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .eph1(eph1), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .core_opmode(core_opmode), .core_input_data(core_input_data),
    .core_textout(core_textout), .core_textout_valid(core_textout_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_text(rsp_text), .rsp_status(rsp_status),
    .busy(busy)
  );

  always #5 eph1 = ~eph1;

  typedef struct {
    bit           legal;
    logic [4:0]   op;
    logic [351:0] data;
    logic [191:0] text;
    logic [1:0]   status;
  } exp_t;

  int           checks = 0;
  int           errors = 0;
  exp_t         exp_q[$];
  logic [4:0]   obs_ops[$];
  logic [191:0] last_text = '0;
  logic [1:0]   last_status = '0;
  int           rsp_cnt = 0;
  int           win_len = 0;
  bit           win_done = 0;
  int           m_mode = 0;  // 0 uninit, 1 hash, 2 keyed
  int           hcnt = 0;
  bit           pulse_en = 1;
  logic [191:0] pulse_text = '0;

  task automatic chk(input string name, input logic [351:0] act, input logic [351:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Core stand-in: pulses textout_valid on the 3rd cycle of each window, junk text elsewhere.
  always @(negedge eph1) begin
    if (core_opmode != 5'h00) hcnt = hcnt + 1;
    else hcnt = 0;
    core_textout_valid = pulse_en && (hcnt == 3);
    core_textout = (hcnt == 3) ? pulse_text : ~pulse_text;
  end

  always @(negedge eph1) begin
    if (reset) begin
      win_len  = 0;
      win_done = 0;
      exp_q.delete();
    end else begin
      if (core_opmode != 5'h00) begin
        if (win_len == 0) begin
          if (exp_q.size() == 0 || !exp_q[0].legal || win_done) begin
            checks++; errors++;
            $display("FAIL unexpected_issue actual=%0h required=no_issue", core_opmode);
          end else begin
            chk("issue_op", 352'(core_opmode), 352'(exp_q[0].op));
          end
          obs_ops.push_back(core_opmode);
        end
        if (exp_q.size() != 0) chk("issue_data", core_input_data, exp_q[0].data);
        chk("rsp_during_issue", 352'(rsp_valid), 352'(0));
        win_len++;
      end else begin
        chk("idle_data", core_input_data, 352'(0));
        if (win_len != 0) begin
          chk("hold_len", 352'(win_len), 352'(HOLD));
          win_len  = 0;
          win_done = 1;
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp actual=status%0d required=no_response", rsp_status);
        end else begin
          chk("rsp_text", 352'(rsp_text), 352'(exp_q[0].text));
          chk("rsp_status", 352'(rsp_status), 352'(exp_q[0].status));
          chk("window_issued", 352'(win_done), 352'(exp_q[0].legal));
          last_text   = rsp_text;
          last_status = rsp_status;
          void'(exp_q.pop_front());
          win_done = 0;
          rsp_cnt++;
        end
      end
    end
  end

  task automatic push_cmd(input logic [4:0] op, input logic [351:0] d);
    exp_t e;
    int   n = 0;
    bit   outfn;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    while (!cmd_ready && n < 200) begin
      @(posedge eph1); #1;
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL push_timeout actual=cmd_ready_low required=accept op=%0h", op);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge eph1); #1;
    cmd_valid = 1'b0;
    outfn  = (op[3:0] == 4'd4) || (op[3:0] == 4'd5) || (op[3:0] == 4'd6) || (op[3:0] == 4'd8);
    e.legal = 1;
    e.op    = op;
    e.data  = d;
`ifdef XOODYAK_SEQ_CHECK_EN
    case (op)
      5'h10:                             m_mode = 1;
      5'h01:                             m_mode = 2;
      5'h03, 5'h06:                      e.legal = (m_mode != 0);
      5'h02, 5'h04, 5'h05, 5'h07, 5'h08: e.legal = (m_mode == 2);
      default:                           e.legal = 0;
    endcase
    e.op = {m_mode == 1, op[3:0]};
`endif
    if (!e.legal)     begin e.status = 2'd1; e.text = '0;         end
    else if (!outfn)  begin e.status = 2'd0; e.text = '0;         end
    else if (pulse_en) begin e.status = 2'd0; e.text = pulse_text; end
    else              begin e.status = 2'd2; e.text = '0;         end
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      @(posedge eph1); #1;
      n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=pending%0d required=0", exp_q.size());
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge eph1); #1;
    @(posedge eph1); #1;
    reset  = 1'b0;
    m_mode = 0;
  endtask

  initial begin
    int k;
    int base;
    bit seen;
    @(posedge eph1); #1;
    do_reset();

    chk("rst_cmd_ready", 352'(cmd_ready), 352'(1));
    chk("rst_rsp_valid", 352'(rsp_valid), 352'(0));
    chk("rst_rsp_text", 352'(rsp_text), 352'(0));
    chk("rst_rsp_status", 352'(rsp_status), 352'(0));
    chk("rst_busy", 352'(busy), 352'(0));
    chk("rst_opmode", 352'(core_opmode), 352'(0));
    chk("rst_data", core_input_data, 352'(0));

    // Hash flow, with push-to-response latency measured on the first command
    pulse_text = HASH_TXT;
    obs_ops.delete();
    push_cmd(5'h10, '0);
    k = 0;
    while (!rsp_valid && k < 20) begin
      @(posedge eph1); #1;
      k++;
    end
    chk("latency", 352'(k), 352'(HOLD + 1));
    push_cmd(5'h03, ABSORB_D);
    push_cmd(5'h06, '0);
    drain();
    chk("hash_nwin", 352'(obs_ops.size()), 352'(3));
    if (obs_ops.size() == 3) begin
      chk("hash_op0", 352'(obs_ops[0]), 352'(5'h10));
      chk("hash_op1", 352'(obs_ops[1]), 352'(ABS_OP));
      chk("hash_op2", 352'(obs_ops[2]), 352'(SQZ_OP));
    end
    chk("hash_sqz_text", 352'(last_text), 352'(HASH_TXT));
    chk("hash_sqz_status", 352'(last_status), 352'(0));

    // Keyed flow
    pulse_text = ENC_TXT;
    obs_ops.delete();
    push_cmd(5'h01, KEY_D);
    push_cmd(5'h02, NONCE_D);
    push_cmd(5'h04, ENC_D);
    drain();
    chk("keyed_nwin", 352'(obs_ops.size()), 352'(3));
    if (obs_ops.size() == 3) begin
      chk("keyed_op0", 352'(obs_ops[0]), 352'(5'h01));
      chk("keyed_op1", 352'(obs_ops[1]), 352'(5'h02));
      chk("keyed_op2", 352'(obs_ops[2]), 352'(5'h04));
    end
    chk("enc_text", 352'(last_text), 352'(ENC_TXT));
    chk("enc_status", 352'(last_status), 352'(0));

    // Missing output
    pulse_en = 0;
    push_cmd(5'h04, ENC_D);
    drain();
    pulse_en = 1;
    chk("missing_status", 352'(last_status), 352'(2));
    chk("missing_text", 352'(last_text), 352'(0));

    // Illegal order
    do_reset();
    obs_ops.delete();
    push_cmd(5'h02, NONCE_D);
    drain();
    chk("ill_uninit_status", 352'(last_status), 352'(ILL_ST));
    chk("ill_uninit_win", 352'(obs_ops.size()), 352'(ILL_WIN));
    push_cmd(5'h10, '0);
    push_cmd(5'h02, NONCE_D);
    drain();
    chk("ill_hash_status", 352'(last_status), 352'(ILL_ST));

    // Backpressure and full FIFO
    push_cmd(5'h01, KEY_D);
    drain();
    base = rsp_cnt;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      push_cmd((i % 2 == 0) ? 5'h03 : 5'h04, {32'(i + 1), 320'h0});
    repeat (3) begin @(posedge eph1); #1; end
    chk("full_cmd_ready", 352'(cmd_ready), 352'(0));
    chk("full_busy", 352'(busy), 352'(1));
    chk("stall_rsp_valid", 352'(rsp_valid), 352'(1));
    chk("stall_no_rsp", 352'(rsp_cnt - base), 352'(0));
    rsp_ready = 1'b1;
    push_cmd(5'h03, {32'd6, 320'h0});
    drain();
    chk("bp_rsp_count", 352'(rsp_cnt - base), 352'(6));

    // Reset during the second hold cycle
    push_cmd(5'h03, ABSORB_D);
    k = 0;
    while (core_opmode == 5'h00 && k < 20) begin
      @(posedge eph1); #1;
      k++;
    end
    chk("rst_mid_reached", 352'(core_opmode != 5'h00), 352'(1));
    @(posedge eph1); #1;
    reset = 1'b1;
    @(posedge eph1); #1;
    chk("rst_mid_opmode", 352'(core_opmode), 352'(0));
    chk("rst_mid_busy", 352'(busy), 352'(0));
    chk("rst_mid_cmd_ready", 352'(cmd_ready), 352'(1));
    reset  = 1'b0;
    m_mode = 0;
    seen = 0;
    repeat (10) begin
      @(posedge eph1); #1;
      seen |= rsp_valid;
    end
    chk("rst_mid_no_rsp", 352'(seen), 352'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
